// File: rtl/sub_borrow_pipe.sv
// sub_borrow_pipe: pipelined X - Y - borrow with valid/ready handshake, one bit slice per stage.
// Each stage carries the full operands forward so the last stage can derive signed overflow.
module sub_borrow_pipe #(
    parameter int p_WIDTH  = 8,
    parameter int p_STAGES = 2
) (
    input  logic               iw_clk,
    input  logic               iw_rst_n,
    input  logic               iw_valid,
    output logic               wo_ready,
    input  logic [p_WIDTH-1:0] iwv_x,
    input  logic [p_WIDTH-1:0] iwv_y,
    input  logic               iw_borrow,
    output logic               wo_valid,
    input  logic               iw_ready,
    output logic [p_WIDTH-1:0] wov_diff,
    output logic               wo_borrow,
    output logic               wo_overflow
);
    localparam int W = p_WIDTH;
    localparam int S = p_STAGES;
    localparam int C = (W + S - 1) / S;

    logic [S-1:0] r_v, r_b;
    logic [W-1:0] r_x [S];
    logic [W-1:0] r_y [S];
    logic [W-1:0] r_d [S];
    logic [S-1:0] w_vi, w_ci, w_bn, w_adv;
    logic [W-1:0] w_xi [S];
    logic [W-1:0] w_yi [S];
    logic [W-1:0] w_di [S];
    logic [W-1:0] w_dn [S];
    logic         w_a;

    // Walk from the output back so each stage sees whether its successor moves.
    always_comb begin
        w_adv = '0;
        w_a   = iw_ready;
        for (int k = S - 1; k >= 0; k--) begin
            w_a      = !r_v[k] || w_a;
            w_adv[k] = w_a;
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_st
        localparam int L = k * C;
        localparam int N = (L + C > W) ? W - L : C;
        if (k == 0) begin : g_in
            assign w_vi[k] = iw_valid;
            assign w_xi[k] = iwv_x;
            assign w_yi[k] = iwv_y;
            assign w_di[k] = '0;
            assign w_ci[k] = ~iw_borrow;
        end else begin : g_link
            assign w_vi[k] = r_v[k-1];
            assign w_xi[k] = r_x[k-1];
            assign w_yi[k] = r_y[k-1];
            assign w_di[k] = r_d[k-1];
            assign w_ci[k] = ~r_b[k-1];
        end
        if (N > 0) begin : g_sl
            localparam logic [W-1:0] M = ({W{1'b1}} >> (W - N)) << L;
            logic [N:0] w_s;
            assign w_s     = {1'b0, w_xi[k][L +: N]} + {1'b0, ~w_yi[k][L +: N]} + {{N{1'b0}}, w_ci[k]};
            assign w_dn[k] = (w_di[k] & ~M) | (W'(w_s[N-1:0]) << L);
            assign w_bn[k] = ~w_s[N];
        end else begin : g_pass
            assign w_dn[k] = w_di[k];
            assign w_bn[k] = ~w_ci[k];
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_v <= '0;
            r_b <= '0;
            for (int k = 0; k < S; k++) begin
                r_x[k] <= '0;
                r_y[k] <= '0;
                r_d[k] <= '0;
            end
        end else begin
            for (int k = 0; k < S; k++) begin
                if (w_adv[k]) begin
                    r_v[k] <= w_vi[k];
                    r_b[k] <= w_bn[k];
                    r_x[k] <= w_xi[k];
                    r_y[k] <= w_yi[k];
                    r_d[k] <= w_dn[k];
                end
            end
        end
    end

    assign wo_ready    = iw_rst_n && w_adv[0];
    assign wo_valid    = r_v[S-1];
    assign wov_diff    = r_d[S-1];
    assign wo_borrow   = r_b[S-1];
    assign wo_overflow = (r_x[S-1][W-1] != r_y[S-1][W-1]) && (r_d[S-1][W-1] != r_x[S-1][W-1]);
endmodule
